clk_div_ctrl: RTL
=================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the divide ratio.
REQ-002 Parameter: DIV_RST, 3, divide ratio loaded at reset; SHALL be >= 2.
REQ-003 Port: clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: en  input  1  run request for the divided clock.
REQ-006 Port: cfg_valid  input  1  new ratio offered.
REQ-007 Port: cfg_div  input  WIDTH  offered ratio N.
REQ-008 Port: cfg_ready  output  1  controller can accept a ratio.
REQ-009 Port: cfg_err  output  1  one-cycle pulse when an illegal ratio is rejected.
REQ-010 Port: clk_out  output  1  registered divided clock.
REQ-011 Port: tick  output  1  one-cycle pulse at the start of each clk_out period.
REQ-012 Port: div_cur  output  WIDTH  ratio currently in effect.
REQ-013 Port: busy  output  1  high in RUN or SWITCH.

Function
REQ-014 The controller SHALL have states IDLE, RUN and SWITCH, with a period counter cnt in the range 0..div_cur-1.
REQ-015 In RUN or SWITCH, cnt SHALL increment each cycle and wrap from div_cur-1 to 0; that wrap cycle is the boundary.
REQ-016 clk_out SHALL be 1 when busy and cnt < (div_cur+1)>>1, and 0 otherwise; high time is ceil(N/2) cycles and low time is floor(N/2) cycles.
REQ-017 cnt, clk_out and tick SHALL all be registered, with no combinational path from inputs to outputs.
REQ-018 tick SHALL be 1 exactly in the cycles where busy and cnt==0.
REQ-019 IDLE to RUN: when en==1 in IDLE, the next cycle SHALL be RUN with cnt=0 (clk_out=1, tick=1).
REQ-020 RUN or SWITCH with en==0: the controller SHALL finish the current period and enter IDLE after the boundary, with clk_out=0 and cnt=0; there SHALL be no truncated high or low phase.
REQ-021 Handshake: a transfer occurs when cfg_valid && cfg_ready; cfg_ready SHALL be 1 in IDLE and RUN, and 0 in SWITCH and during reset.
REQ-022 A transfer with cfg_div < 2 SHALL be rejected: cfg_err=1 for the next cycle, and state and div_cur unchanged.
REQ-023 A legal transfer in IDLE SHALL set div_cur to cfg_div in the next cycle; state stays IDLE.
REQ-024 A legal transfer in RUN that is not a boundary cycle SHALL store the value as pending and enter SWITCH.
REQ-025 At the next boundary in SWITCH, div_cur SHALL take the pending value, cnt SHALL go to 0, and the state SHALL return to RUN (or IDLE if en==0).
REQ-026 A legal transfer in RUN on a boundary cycle SHALL apply immediately: the next period uses the new N and the state stays RUN.
REQ-027 A ratio change SHALL take effect only at a period boundary; the periods before and after the change SHALL each be complete.
REQ-028 en==0 together with a pending change: the pending value SHALL be applied at the boundary and the state SHALL then be IDLE.
REQ-029 div_cur is constant within a period, so cnt never exceeds div_cur-1; maximum N = 2^WIDTH-1.

Reset
REQ-030 While rst_n==0 at a rising edge, the next state SHALL be IDLE, with cnt=0, clk_out=0, tick=0, cfg_err=0, busy=0, cfg_ready=0, div_cur=DIV_RST, and the pending value cleared.
REQ-031 Reset asserted mid-period or in SWITCH SHALL abort immediately; the pending ratio is discarded.
REQ-032 cfg_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification
REQ-033 Reset, then en=1 with DIV_RST=3 -> clk_out pattern 1,1,0 repeating; tick every 3rd cycle; div_cur=3.
REQ-034 RUN with N=3; offer cfg_div=4 at cnt=1 -> SWITCH and cfg_ready=0; the current period completes with 3 cycles; the next period is 1,1,0,0; the state returns to RUN.
REQ-035 Offer cfg_div=1, then cfg_div=0 -> cfg_err pulses once per transfer; div_cur and the clk_out pattern are unchanged.
REQ-036 N=5, drop en at cnt=1 -> the period completes (1,1,1,0,0), then clk_out=0, busy=0 and no further ticks; raise en -> clk_out=1 with tick=1 on the next cycle.
REQ-037 In SWITCH (pending 6), assert rst_n=0 for 1 cycle -> all reset values from REQ-030, div_cur=3, and the pending 6 is never applied.
REQ-038 Offer cfg_div=2 in the boundary cycle of an N=4 run -> the following periods are 1,0; there is no SWITCH state and cfg_ready stays 1.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with a valid/ready ratio port; ratio changes land only on period boundaries.
// Latency: all outputs registered, one cycle after the controlling input; cfg_ready drops while a change is pending.
module clk_div_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DIV_RST = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W     = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_X     = (WIDTH+1)'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend;
  logic             r_clk;
  logic             r_tick;
  logic             r_err;
  logic             r_rdy;

  state_t           w_state_n;
  logic [WIDTH-1:0] w_cnt_n;
  logic [WIDTH-1:0] w_div_n;
  logic [WIDTH-1:0] w_pend_n;
  logic             w_busy_n;
  logic [WIDTH:0]   w_half_n;
  logic             w_clk_n;
  logic             w_tick_n;
  logic             w_err_n;
  logic             w_rdy_n;
  logic             w_xfer;
  logic             w_legal;
  logic             w_bnd;

  assign w_xfer  = cfg_valid && r_rdy;
  assign w_legal = (cfg_div >= TWO_W);
  assign w_bnd   = (r_state != S_IDLE) && (r_cnt == (r_div - ONE_W));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= DIV_RST_W;
      r_pend  <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_err   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_div   <= w_div_n;
      r_pend  <= w_pend_n;
      r_clk   <= w_clk_n;
      r_tick  <= w_tick_n;
      r_err   <= w_err_n;
      r_rdy   <= w_rdy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_div_n   = r_div;
    w_pend_n  = r_pend;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (w_xfer && w_legal) w_div_n = cfg_div;
        if (en) w_state_n = S_RUN;
      end
      S_RUN: begin
        w_cnt_n = w_bnd ? '0 : r_cnt + ONE_W;
        if (w_xfer && w_legal) begin
          // On the boundary the new ratio can start the very next period.
          if (w_bnd) begin
            w_div_n = cfg_div;
            if (!en) w_state_n = S_IDLE;
          end else begin
            w_pend_n  = cfg_div;
            w_state_n = S_SWITCH;
          end
        end else if (w_bnd && !en) begin
          w_state_n = S_IDLE;
        end
      end
      S_SWITCH: begin
        w_cnt_n = w_bnd ? '0 : r_cnt + ONE_W;
        if (w_bnd) begin
          w_div_n   = r_pend;
          w_pend_n  = '0;
          w_state_n = en ? S_RUN : S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so they can be registered.
  always_comb begin
    w_busy_n = (w_state_n != S_IDLE);
    w_half_n = ({1'b0, w_div_n} + ONE_X) >> 1;
    w_clk_n  = w_busy_n && ({1'b0, w_cnt_n} < w_half_n);
    w_tick_n = w_busy_n && (w_cnt_n == '0);
    w_err_n  = w_xfer && !w_legal;
    w_rdy_n  = (w_state_n != S_SWITCH);
  end

  assign cfg_ready = r_rdy;
  assign cfg_err   = r_err;
  assign clk_out   = r_clk;
  assign tick      = r_tick;
  assign div_cur   = r_div;
  assign busy      = (r_state != S_IDLE);

endmodule
